// File: rtl/snn_step_sched.sv
// Timestep scheduler for a bank of single-synapse integrate-and-fire neurons.
// Optional spike counter output enabled by defining SNN_SPIKE_COUNT_EN.
module snn_step_sched #(
   parameter int  NUM_NEURONS = 8,
   parameter int  TIMESTEPS   = 16,
   localparam int STEP_W      = ($clog2(TIMESTEPS) > 0) ? $clog2(TIMESTEPS) : 1,
   localparam int CNT_W       = $clog2(NUM_NEURONS * TIMESTEPS + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   cfg_valid_i,
   output logic                   cfg_ready_o,
   input  logic [NUM_NEURONS-1:0] cfg_syn_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [NUM_NEURONS-1:0] in_axon_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [NUM_NEURONS-1:0] out_spike_o,
   output logic [STEP_W-1:0]      out_step_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   neuron_rst_o,
   output logic [NUM_NEURONS-1:0] neuron_syn_o,
   output logic [NUM_NEURONS-1:0] neuron_axon_o,
   input  logic [NUM_NEURONS-1:0] neuron_spike_i
`ifdef SNN_SPIKE_COUNT_EN
   ,
   output logic [CNT_W-1:0]       spike_count_o
`endif
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CONFIG  = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_FIRE    = 3'd3;
   localparam logic [2:0] S_SETTLE  = 3'd4;
   localparam logic [2:0] S_CAPTURE = 3'd5;
   localparam logic [2:0] S_EMIT    = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   logic [2:0]             state_q;
   logic [STEP_W-1:0]      step_q;
   logic [NUM_NEURONS-1:0] syn_q;
   logic [NUM_NEURONS-1:0] axon_q;
   logic [NUM_NEURONS-1:0] spike_q;
   logic [STEP_W-1:0]      out_step_q;
   logic                   last_step;

   assign last_step = (step_q == STEP_W'(TIMESTEPS - 1));

   // Handshake strobes decode straight from state, so at most one is ever high.
   assign cfg_ready_o   = (state_q == S_CONFIG);
   assign in_ready_o    = (state_q == S_WAIT);
   assign out_valid_o   = (state_q == S_EMIT);
   assign done_o        = (state_q == S_DONE);
   assign busy_o        = (state_q != S_IDLE);
   assign neuron_rst_o  = (state_q == S_IDLE) || (state_q == S_CONFIG) || (state_q == S_DONE);
   assign neuron_syn_o  = syn_q;
   assign neuron_axon_o = axon_q;
   assign out_spike_o   = spike_q;
   assign out_step_o    = out_step_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         step_q     <= '0;
         syn_q      <= '0;
         axon_q     <= '0;
         spike_q    <= '0;
         out_step_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (start_i) state_q <= S_CONFIG;
            S_CONFIG: begin
               if (cfg_valid_i) begin
                  syn_q   <= cfg_syn_i;
                  step_q  <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (in_valid_i) begin
                  axon_q  <= in_axon_i;
                  state_q <= S_FIRE;
               end
            end
            S_FIRE: begin
               axon_q  <= '0;
               state_q <= S_SETTLE;
            end
            S_SETTLE: state_q <= S_CAPTURE;
            S_CAPTURE: begin
               spike_q    <= neuron_spike_i;
               out_step_q <= step_q;
               state_q    <= S_EMIT;
            end
            S_EMIT: begin
               if (out_ready_i) begin
                  if (last_step) begin
                     state_q <= S_DONE;
                  end else begin
                     step_q  <= step_q + STEP_W'(1);
                     state_q <= S_WAIT;
                  end
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef SNN_SPIKE_COUNT_EN
   logic [CNT_W-1:0] pop;
   logic [CNT_W-1:0] count_q;

   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
         pop = pop + CNT_W'(neuron_spike_i[i]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (state_q == S_CONFIG && cfg_valid_i) begin
         count_q <= '0;
      end else if (state_q == S_CAPTURE) begin
         count_q <= count_q + pop;
      end
   end

   assign spike_count_o = count_q;
`endif

endmodule
